// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : mem_port_arbiter
// Brief    : Shares one memory port between icache refill and dcache
//            refill/writeback. Transfers are issued one at a time.
//            Define ARB_RR_EN for round-robin arbitration; without it the
//            dcache has fixed priority.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic              ic_abort,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_done,
    output logic [LINE_W-1:0] rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [LINE_W-1:0] mem_rdata
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    localparam logic [1:0] c_OWN_NONE = 2'd0;
    localparam logic [1:0] c_OWN_IC   = 2'd1;
    localparam logic [1:0] c_OWN_DC   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic              aborted_q, aborted_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              ic_done_q, ic_done_d;
    logic              dc_done_q, dc_done_d;
    logic              err_q, err_d;

    logic w_ic_pend, w_dc_pend, w_grant_dc, w_timeout, w_abort_now;

    assign w_ic_pend   = ic_req & ~ic_abort;
    assign w_dc_pend   = dc_req;
    assign w_timeout   = (cnt_q == c_CNT_LAST);
    assign w_abort_now = aborted_q | ((owner_q == c_OWN_IC) & ic_abort);

`ifdef ARB_RR_EN
    logic last_grant_q, last_grant_d;   // 1 = dcache was granted last

    assign w_grant_dc = w_dc_pend & (~w_ic_pend | ~last_grant_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last_grant_q <= 1'b0;
        else          last_grant_q <= last_grant_d;
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == c_IDLE && (w_ic_pend || w_dc_pend))
            last_grant_d = w_grant_dc;
    end
`else
    assign w_grant_dc = w_dc_pend;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= c_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (w_ic_pend || w_dc_pend) state_d = c_BUSY;
            c_BUSY:  if (mem_ack || w_timeout)   state_d = c_RESP;
            c_RESP:  state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        owner_d     = owner_q;
        aborted_d   = aborted_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        ic_done_d   = 1'b0;
        dc_done_d   = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (w_ic_pend || w_dc_pend) begin
                    mem_req_d = 1'b1;
                    cnt_d     = '0;
                    aborted_d = 1'b0;
                    if (w_grant_dc) begin
                        owner_d     = c_OWN_DC;
                        mem_we_d    = dc_we;
                        mem_addr_d  = dc_addr;
                        mem_wdata_d = dc_wdata;
                    end else begin
                        owner_d     = c_OWN_IC;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = ic_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            c_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (owner_q == c_OWN_IC && ic_abort) aborted_d = 1'b1;
                // Done is registered here so it appears in the RESP cycle;
                // an abort seen this cycle must already suppress it.
                if (mem_ack || w_timeout) begin
                    mem_req_d = 1'b0;
                    ic_done_d = (owner_q == c_OWN_IC) & ~w_abort_now;
                    dc_done_d = (owner_q == c_OWN_DC);
                    err_d     = ~mem_ack & ((owner_q == c_OWN_DC) | ~w_abort_now);
                    if (mem_ack) rdata_d = mem_rdata;
                end
            end
            c_RESP: begin
                owner_d   = c_OWN_NONE;
                aborted_d = 1'b0;
                cnt_d     = '0;
            end
            default: begin
                owner_d   = c_OWN_NONE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q     <= c_OWN_NONE;
            aborted_q   <= 1'b0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            ic_done_q   <= 1'b0;
            dc_done_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            aborted_q   <= aborted_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            ic_done_q   <= ic_done_d;
            dc_done_q   <= dc_done_d;
            err_q       <= err_d;
        end
    end

    assign ic_done   = ic_done_q;
    assign dc_done   = dc_done_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter (TIMEOUT=8).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 128;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              ic_req, ic_abort, dc_req, dc_we, mem_ack;
    logic [ADDR_W-1:0] ic_addr, dc_addr;
    logic [LINE_W-1:0] dc_wdata, mem_rdata;
    logic              ic_done, dc_done, err, mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] rdata, mem_wdata;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [LINE_W-1:0] c_D1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [LINE_W-1:0] c_D2 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEED_F00D;
    localparam logic [LINE_W-1:0] c_D3 = 128'hCAFE_0000_1234_0000_5678_0000_9ABC_0001;
    localparam logic [LINE_W-1:0] c_A5 = {16{8'hA5}};

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ic_req   (ic_req),
        .ic_addr  (ic_addr),
        .ic_abort (ic_abort),
        .ic_done  (ic_done),
        .dc_req   (dc_req),
        .dc_we    (dc_we),
        .dc_addr  (dc_addr),
        .dc_wdata (dc_wdata),
        .dc_done  (dc_done),
        .rdata    (rdata),
        .err      (err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                         input logic [LINE_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the first BUSY cycle: waits lat cycles, then acks for one cycle.
    task automatic serve(input int lat, input logic [LINE_W-1:0] rd);
        repeat (lat) step();
        check("req_before_ack", mem_req, 1);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        step();
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    initial begin
        reset_n = 1'b0; ic_req = 0; ic_abort = 0; dc_req = 0; dc_we = 0;
        mem_ack = 0; ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0;
        repeat (3) step();
        check("rst_mem_req", mem_req, 0);
        check("rst_done", {ic_done, dc_done, err, mem_we}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_rdata", rdata, 0);
        reset_n = 1'b1;

        // single icache read, ack 4 cycles after mem_req
        ic_req = 1; ic_addr = 32'h100;
        step();
        check("ic_mem_req", mem_req, 1);
        check("ic_mem_addr", mem_addr, 32'h100);
        check("ic_mem_we", mem_we, 0);
        serve(4, c_D1);
        check("ic_done", ic_done, 1);
        check("ic_rdata", rdata, c_D1);
        check("ic_err", err, 0);
        check("ic_req_drop", mem_req, 0);
        ic_req = 0;
        step();
        check("ic_done_once", ic_done, 0);

        // mem_ack while idle is ignored
        mem_ack = 1; mem_rdata = c_D3;
        step();
        mem_ack = 0; mem_rdata = '0;
        step();
        check("stray_ack_done", {ic_done, dc_done}, 0);
        check("stray_ack_rdata", rdata, c_D1);

        // dcache writeback
        dc_req = 1; dc_we = 1; dc_addr = 32'h2000; dc_wdata = c_A5;
        step();
        check("wb_mem_we", mem_we, 1);
        check("wb_mem_addr", mem_addr, 32'h2000);
        check("wb_mem_wdata", mem_wdata, c_A5);
        serve(2, c_D3);
        check("wb_dc_done", dc_done, 1);
        check("wb_ic_done", ic_done, 0);
        check("wb_err", err, 0);
        dc_req = 0; dc_we = 0;
        step();
        check("wb_done_once", dc_done, 0);

        // simultaneous requests, both held until their own done
        ic_req = 1; ic_addr = 32'h40; dc_req = 1; dc_addr = 32'h80;
        step();
`ifdef ARB_RR_EN
        check("sim1_addr", mem_addr, 32'h40);
        serve(1, c_D1);
        check("sim1_ic_done", ic_done, 1);
        check("sim1_dc_done", dc_done, 0);
        ic_req = 0;
        step();
        step();
        check("sim2_addr", mem_addr, 32'h80);
        serve(0, c_D2);
        check("sim2_dc_done", dc_done, 1);
        check("sim2_rdata", rdata, c_D2);
        dc_req = 0;
`else
        check("sim1_addr", mem_addr, 32'h80);
        serve(1, c_D1);
        check("sim1_dc_done", dc_done, 1);
        check("sim1_ic_done", ic_done, 0);
        dc_req = 0;
        step();
        step();
        check("sim2_addr", mem_addr, 32'h40);
        check("sim2_we", mem_we, 0);
        serve(0, c_D2);
        check("sim2_ic_done", ic_done, 1);
        check("sim2_rdata", rdata, c_D2);
        ic_req = 0;
`endif
        step();

        // abort in flight with a dcache request queued behind it
        ic_req = 1; ic_addr = 32'h300;
        step();
        dc_req = 1; dc_addr = 32'h400;
        step();
        ic_abort = 1;
        step();
        ic_abort = 0; ic_req = 0;
        check("ab_mem_req", mem_req, 1);
        check("ab_mem_addr", mem_addr, 32'h300);
        step();
        mem_ack = 1; mem_rdata = c_D3;
        step();
        mem_ack = 0; mem_rdata = '0;
        check("ab_no_done", {ic_done, dc_done, err}, 0);
        check("ab_req_drop", mem_req, 0);
        step();
        check("ab_idle_no_done", ic_done, 0);
        step();
        check("ab_dc_addr", mem_addr, 32'h400);
        serve(0, c_D1);
        check("ab_dc_done", dc_done, 1);
        check("ab_dc_rdata", rdata, c_D1);
        dc_req = 0;
        step();

        // timeout: 8 BUSY cycles with no ack
        dc_req = 1; dc_addr = 32'h500;
        step();
        repeat (TIMEOUT - 1) step();
        check("to_req_held", mem_req, 1);
        step();
        check("to_req_drop", mem_req, 0);
        check("to_dc_done", dc_done, 1);
        check("to_err", err, 1);
        dc_req = 0;
        step();
        check("to_clear", {dc_done, err}, 0);

        // ack in the last allowed cycle wins over the timeout
        dc_req = 1; dc_addr = 32'h540;
        step();
        serve(TIMEOUT - 1, c_D2);
        check("ackto_done", dc_done, 1);
        check("ackto_err", err, 0);
        check("ackto_rdata", rdata, c_D2);
        dc_req = 0;
        step();

        // reset mid-transfer, then the request completes normally
        ic_req = 1; ic_addr = 32'h600;
        step();
        step();
        reset_n = 1'b0;
        #1;
        check("mr_req", mem_req, 0);
        check("mr_addr", mem_addr, 0);
        step();
        check("mr_no_done", {ic_done, dc_done, err}, 0);
        reset_n = 1'b1;
        step();
        check("mr_re_addr", mem_addr, 32'h600);
        check("mr_re_req", mem_req, 1);
        serve(1, c_D3);
        check("mr_done", ic_done, 1);
        check("mr_rdata", rdata, c_D3);
        ic_req = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
